// File: rtl/edge_event_arbiter.sv
// Edge detector with per-channel pending flags and a round-robin event port.
// Define EDGE_EVENT_ARBITER_OVERFLOW_EN to add sticky OVERFLOW flags and OVF_CLR.
module edge_event_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NUM_CH-1:0] SAMPLE_IN,
   input  logic [NUM_CH-1:0] RISE_EN,
   input  logic [NUM_CH-1:0] FALL_EN,
   output logic              EVT_VALID,
   input  logic              EVT_READY,
   output logic [CH_W-1:0]   EVT_CH,
   output logic              EVT_RISE,
   output logic [NUM_CH-1:0] PENDING
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
   ,
   output logic [NUM_CH-1:0] OVERFLOW,
   input  logic              OVF_CLR
`endif
);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t            state;
   logic [NUM_CH-1:0] s_old, s_new;
   logic [NUM_CH-1:0] rise, fall, hit, acc, ptype, req;
   logic [CH_W-1:0]   last, base, win;
   logic [CH_W:0]     idx;
   logic              win_ok, hs;

   assign rise = ~s_old & s_new;
   assign fall = s_old & ~s_new;
   assign hit  = (rise & RISE_EN) | (fall & FALL_EN);
   assign hs   = EVT_VALID & EVT_READY;

   always_comb begin
      acc = '0;
      if (hs) acc[EVT_CH] = 1'b1;
   end

   // In OFFER the search restarts after the channel being accepted.
   always_comb begin
      base   = (state == OFFER) ? EVT_CH : last;
      req    = (state == OFFER) ? (PENDING & ~acc) : PENDING;
      win    = '0;
      win_ok = 1'b0;
      idx    = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = {1'b0, base} + (CH_W+1)'(i);
         if (idx >= (CH_W+1)'(NUM_CH))
            idx = idx - (CH_W+1)'(NUM_CH);
         if (!win_ok && req[idx[CH_W-1:0]]) begin
            win_ok = 1'b1;
            win    = idx[CH_W-1:0];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s_old   <= '0;
         s_new   <= '0;
         PENDING <= '0;
         ptype   <= '0;
      end else begin
         s_old <= s_new;
         s_new <= SAMPLE_IN;
         for (int i = 0; i < NUM_CH; i++) begin
            if (hit[i] && (!PENDING[i] || acc[i])) begin
               PENDING[i] <= 1'b1;
               ptype[i]   <= rise[i];
            end else if (acc[i]) begin
               PENDING[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         EVT_VALID <= 1'b0;
         EVT_CH    <= '0;
         EVT_RISE  <= 1'b0;
         last      <= CH_W'(NUM_CH - 1);
      end else begin
         case (state)
            IDLE: begin
               if (win_ok) begin
                  state     <= OFFER;
                  EVT_VALID <= 1'b1;
                  EVT_CH    <= win;
                  EVT_RISE  <= ptype[win];
               end
            end
            OFFER: begin
               if (hs) begin
                  last <= EVT_CH;
                  if (win_ok) begin
                     EVT_CH   <= win;
                     EVT_RISE <= ptype[win];
                  end else begin
                     state     <= IDLE;
                     EVT_VALID <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
   logic [NUM_CH-1:0] dropped;

   assign dropped = hit & PENDING & ~acc;

   // A drop in the same cycle as OVF_CLR must remain visible.
   always_ff @(posedge CLK) begin
      if (RST)
         OVERFLOW <= '0;
      else
         OVERFLOW <= dropped | (OVF_CLR ? '0 : OVERFLOW);
   end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed steps then random traffic
// against an event-level reference model.
module tb_edge_event_arbiter;

   localparam int N = 4;

   logic         CLK = 1'b0;
   logic         RST;
   logic [N-1:0] SAMPLE_IN, RISE_EN, FALL_EN, PENDING;
   logic         EVT_VALID, EVT_READY, EVT_RISE;
   logic [1:0]   EVT_CH;
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
   logic [N-1:0] OVERFLOW;
   logic         OVF_CLR;
`endif

   edge_event_arbiter #(.NUM_CH(N)) dut (
      .CLK(CLK), .RST(RST), .SAMPLE_IN(SAMPLE_IN),
      .RISE_EN(RISE_EN), .FALL_EN(FALL_EN),
      .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY),
      .EVT_CH(EVT_CH), .EVT_RISE(EVT_RISE), .PENDING(PENDING)
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
      , .OVERFLOW(OVERFLOW), .OVF_CLR(OVF_CLR)
`endif
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // model: last two samples, pending events, grant register
   bit m_s0[N], m_s1[N], m_pend[N], m_typ[N], m_ovf[N];
   bit m_valid, m_rise;
   int m_ch, m_last;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input bit p[N], input int start);
      for (int k = 1; k <= N; k++)
         if (p[(start + k) % N]) return (start + k) % N;
      return -1;
   endfunction

   function automatic logic [31:0] pack(input bit p[N]);
      logic [31:0] v = '0;
      for (int c = 0; c < N; c++) v[c] = p[c];
      return v;
   endfunction

   task automatic model_update();
      bit np[N], nt[N], no[N], tmp[N];
      bit hs, ev, acc, clr;
      int w;
      if (RST) begin
         for (int c = 0; c < N; c++) begin
            m_s0[c] = 0; m_s1[c] = 0; m_pend[c] = 0;
            m_typ[c] = 0; m_ovf[c] = 0;
         end
         m_valid = 0; m_rise = 0; m_ch = 0; m_last = N - 1;
         return;
      end
      clr = 0;
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
      clr = OVF_CLR;
`endif
      hs = m_valid && EVT_READY;
      for (int c = 0; c < N; c++) begin
         np[c] = m_pend[c]; nt[c] = m_typ[c]; no[c] = m_ovf[c];
         ev  = (m_s1[c] != m_s0[c]) && (m_s1[c] ? RISE_EN[c] : FALL_EN[c]);
         acc = hs && (m_ch == c);
         if (ev && (!m_pend[c] || acc)) begin
            np[c] = 1; nt[c] = m_s1[c];
         end else if (acc) begin
            np[c] = 0;
         end
         if (ev && m_pend[c] && !acc) no[c] = 1;
         else if (clr) no[c] = 0;
      end
      if (!m_valid) begin
         w = pick(m_pend, m_last);
         if (w >= 0) begin
            m_valid = 1; m_ch = w; m_rise = m_typ[w];
         end
      end else if (hs) begin
         m_last = m_ch;
         tmp = m_pend;
         tmp[m_ch] = 0;
         w = pick(tmp, m_ch);
         if (w >= 0) begin
            m_ch = w; m_rise = m_typ[w];
         end else begin
            m_valid = 0;
         end
      end
      for (int c = 0; c < N; c++) begin
         m_pend[c] = np[c]; m_typ[c] = nt[c]; m_ovf[c] = no[c];
         m_s0[c] = m_s1[c]; m_s1[c] = SAMPLE_IN[c];
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_update();
      #1;
      chk("valid", 32'(EVT_VALID), 32'(m_valid));
      chk("ch", 32'(EVT_CH), m_ch);
      chk("rise", 32'(EVT_RISE), 32'(m_rise));
      chk("pending", 32'(PENDING), pack(m_pend));
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
      chk("overflow", 32'(OVERFLOW), pack(m_ovf));
`endif
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1; SAMPLE_IN = '0; RISE_EN = 4'hF; FALL_EN = '0;
      EVT_READY = 1'b1;
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
      OVF_CLR = 1'b0;
`endif
      step(); step();
      chk("rst_valid", 32'(EVT_VALID), 0);
      chk("rst_ch", 32'(EVT_CH), 0);
      chk("rst_rise", 32'(EVT_RISE), 0);
      chk("rst_pend", 32'(PENDING), 0);
      RST = 1'b0;
      step();

      // basic rise on ch2
      SAMPLE_IN[2] = 1'b1;
      step();
      step();
      chk("basic_pend", 32'(PENDING), 32'h4);
      chk("basic_nv", 32'(EVT_VALID), 0);
      step();
      chk("basic_valid", 32'(EVT_VALID), 1);
      chk("basic_ch", 32'(EVT_CH), 2);
      chk("basic_rise", 32'(EVT_RISE), 1);
      step();
      chk("basic_done", 32'(EVT_VALID), 0);
      chk("basic_clr", 32'(PENDING), 0);

      // stall and hold on ch1 fall
      RISE_EN = '0; FALL_EN = 4'hF;
      SAMPLE_IN[1] = 1'b1;
      repeat (3) step();
      EVT_READY = 1'b0;
      SAMPLE_IN[1] = 1'b0;
      repeat (3) step();
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(EVT_VALID), 1);
         chk("hold_ch", 32'(EVT_CH), 1);
         chk("hold_rise", 32'(EVT_RISE), 0);
         step();
      end
      EVT_READY = 1'b1;
      step();
      chk("hold_done", 32'(EVT_VALID), 0);

      // round robin
      FALL_EN = '0; RISE_EN = 4'hF; SAMPLE_IN = '0;
      do_reset();
      step();
      SAMPLE_IN = 4'b1011;
      step(); step(); step();
      chk("rr_g0", 32'(EVT_CH), 0);
      step();
      chk("rr_g1", 32'(EVT_CH), 1);
      step();
      chk("rr_g3", 32'(EVT_CH), 3);
      chk("rr_v3", 32'(EVT_VALID), 1);
      step();
      chk("rr_end", 32'(EVT_VALID), 0);
      SAMPLE_IN = '0;
      repeat (2) step();
      SAMPLE_IN = 4'b1001;
      step(); step(); step();
      chk("rr2_g0", 32'(EVT_CH), 0);
      step();
      chk("rr2_g3", 32'(EVT_CH), 3);
      step();

      // enable mask: fall only, one-cycle pulse
      SAMPLE_IN = '0;
      do_reset();
      RISE_EN = '0; FALL_EN = 4'hF;
      SAMPLE_IN[0] = 1'b1;
      step();
      SAMPLE_IN[0] = 1'b0;
      step(); step();
      chk("mask_pend", 32'(PENDING), 1);
      step();
      chk("mask_valid", 32'(EVT_VALID), 1);
      chk("mask_rise", 32'(EVT_RISE), 0);
      repeat (3) step();
      chk("mask_once", 32'(EVT_VALID), 0);

`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
      // overflow: rise then fall on stalled ch2
      do_reset();
      RISE_EN = 4'hF; FALL_EN = 4'hF; EVT_READY = 1'b0;
      SAMPLE_IN[2] = 1'b1;
      step();
      SAMPLE_IN[2] = 1'b0;
      repeat (4) step();
      chk("ovf_set", 32'(OVERFLOW), 32'h4);
      chk("ovf_rise", 32'(EVT_RISE), 1);
      EVT_READY = 1'b1;
      repeat (3) step();
      chk("ovf_sticky", 32'(OVERFLOW), 32'h4);
      OVF_CLR = 1'b1;
      step();
      OVF_CLR = 1'b0;
      chk("ovf_clr", 32'(OVERFLOW), 0);
`endif

      // reset mid-offer with input held high
      SAMPLE_IN = '0;
      do_reset();
      RISE_EN = 4'hF; FALL_EN = '0; EVT_READY = 1'b0;
      SAMPLE_IN[3] = 1'b1;
      repeat (3) step();
      chk("mid_valid", 32'(EVT_VALID), 1);
      chk("mid_ch", 32'(EVT_CH), 3);
      RST = 1'b1;
      step();
      chk("mid_rst_v", 32'(EVT_VALID), 0);
      chk("mid_rst_p", 32'(PENDING), 0);
      RST = 1'b0;
      repeat (3) step();
      chk("mid_fresh", 32'(EVT_VALID), 1);
      chk("mid_fresh_ch", 32'(EVT_CH), 3);
      EVT_READY = 1'b1;
      step();

      // random traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 3) == 0) SAMPLE_IN[c] = ~SAMPLE_IN[c];
         if ($urandom_range(0, 31) == 0) RISE_EN = 4'($urandom);
         if ($urandom_range(0, 31) == 0) FALL_EN = 4'($urandom);
         EVT_READY = ($urandom_range(0, 2) != 0);
         RST = ($urandom_range(0, 399) == 0);
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
         OVF_CLR = ($urandom_range(0, 19) == 0);
`endif
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

- Multi-channel edge event controller.
- Edge-detects `NUM_CH` already-synchronous sample lines and latches one pending event per channel.
- Shares a single valid/ready event port between channels with round-robin arbitration.
- Sits between the per-signal sampling logic and the consumer (interrupt/status logic), so that edges are never lost while the consumer stalls (except as specified under overflow).

## Interface
- `NUM_CH`, 4: number of input channels, 2..32.
- `CH_W`, `$clog2(NUM_CH)`: width of the channel index (derived, not overridden).
- `CLK`  in  1  sole clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `SAMPLE_IN`  in  `NUM_CH`  sample lines, already synchronous to `CLK`.
- `RISE_EN`  in  `NUM_CH`  per-channel enable for rising-edge events.
- `FALL_EN`  in  `NUM_CH`  per-channel enable for falling-edge events.
- `EVT_VALID`  out  1  event offered.
- `EVT_READY`  in  1  consumer accepts the event.
- `EVT_CH`  out  `CH_W`  channel index of the offered event.
- `EVT_RISE`  out  1  1 = rising edge, 0 = falling edge.
- `PENDING`  out  `NUM_CH`  registered pending flags.
- `OVERFLOW`  out  `NUM_CH`  sticky overflow flags; present only with the macro under Configuration.
- `OVF_CLR`  in  1  clears all `OVERFLOW` bits; present only with the macro under Configuration.

## Operation
- **Per-channel follower.** 2-bit shift register `{old,new}` per channel, reset to 00.
  - Rise detected when the follower equals 01; fall detected when it equals 10. Detection is combinational from the follower.
  - An input that is high at reset release yields a rise detection.
- **Pending flag and type.** Per channel, set on (rise & `RISE_EN`) or (fall & `FALL_EN`); the type records which edge it was.
- **Clear.** Pending is cleared when that channel's event is accepted (`EVT_VALID & EVT_READY & EVT_CH==ch`).
- **Simultaneous accept and new edge on the same channel.** Set wins; pending stays 1 with the new type.
- **Edge on an already-pending channel (not being accepted).** The edge is dropped; the stored type is kept.
- **Enable changes** affect detection only. Events already pending stay and are delivered.
- **FSM IDLE.**
  - `EVT_VALID`=0.
  - If any `PENDING` bit is set: select the first set channel searching from `last+1` upward, wrapping; register `EVT_CH`/`EVT_RISE`; go to OFFER.
- **FSM OFFER.**
  - `EVT_VALID`=1; `EVT_CH` and `EVT_RISE` are held stable until accepted.
  - On handshake: `last`←`EVT_CH`.
  - If any other pending bit is set (the accepted channel's bit is masked), load the next winner by the same search rule and stay in OFFER. This gives back-to-back events with no bubble.
  - Otherwise go to IDLE.
- **`last` pointer.** Resets to `NUM_CH-1`, so channel 0 has first priority after reset.
- **`EVT_VALID` is never withdrawn** without a handshake.

## Timing
- Reset values: `EVT_VALID`=0, `EVT_CH`=0, `EVT_RISE`=0, `PENDING`=0, `OVERFLOW`=0; FSM=IDLE; followers=00.
- Latency, uncontended channel, FSM idle:
  - `SAMPLE_IN` first sampled high at edge N.
  - `PENDING` set after edge N+1.
  - `EVT_VALID` high after edge N+2.
- Throughput: one event per cycle while `EVT_READY`=1 and events are pending.
- A newly set pending bit is visible to arbitration the cycle after it is set.
- Reset asserted mid-offer: all state clears at the next edge. The in-flight event is discarded with no handshake.
- One-cycle `SAMPLE_IN` pulse: rise and fall are detected on consecutive cycles. If the rise is still pending when the fall is detected, the fall is dropped.

## Configuration
- Macro: `EDGE_EVENT_ARBITER_OVERFLOW_EN`.
- **Defined:**
  - The `OVERFLOW` and `OVF_CLR` ports exist.
  - `OVERFLOW[ch]` sets (sticky) whenever an enabled edge is dropped on ch.
  - `OVF_CLR` clears all bits. If a set and `OVF_CLR` occur in the same cycle, the set wins.
- **Undefined:** the ports and the logic are absent; dropped edges are silent. All other behaviour is identical.

## Test plan
- **Basic rise:** reset, then `SAMPLE_IN[2]` 0→1 with `RISE_EN`=F, `EVT_READY`=1 → `EVT_VALID`=1, `EVT_CH`=2, `EVT_RISE`=1 two edges after first high sample, for exactly 1 cycle. `PENDING` returns to 0.
- **Stall and hold:** ch1 fall, `EVT_READY`=0 for 5 cycles → `EVT_VALID`, `EVT_CH`=1 and `EVT_RISE`=0 stable for all 5 cycles; cleared after `EVT_READY`=1.
- **Round robin:** channels 0,1,3 rise in the same cycle, `EVT_READY`=1 → grants 0,1,3 back-to-back. Next simultaneous 0,3 with `last`=3 → grants 0 then 3.
- **Enable mask:** `RISE_EN`=0, `FALL_EN`=F, 1-cycle pulse on ch0 → single event ch0, `EVT_RISE`=0; no rise event.
- **Overflow (macro on):** `EVT_READY`=0, ch2 rise then fall → one event ch2 rise; `OVERFLOW`=0100 until `OVF_CLR`. Same-cycle accept plus new edge → event retained and delivered next, no overflow.
- **Reset mid-operation:** `RST` pulsed while `EVT_VALID`=1 → outputs at reset values next cycle; an input held high produces a fresh rise event after release.
